spiking_neuron_array: RTL and testbench

Time-multiplexed array of N_CH quadratic integrate-and-fire neurons sharing one signed arithmetic datapath. Each enabled cycle one channel, chosen round-robin, is updated with v' = v + (stim>>SHIFT_IN) + (v>>>SHIFT_SQ)^2, with a threshold reset, a refractory hold and saturation. The block sits behind the pad-mapped top level: stimulus comes from the input switches, spikes and the membrane monitor go out to the display/GPIO pins.

---
 rtl/snn_pkg.sv | 35 +++
 rtl/spiking_neuron_array_if.sv | 31 +++
 rtl/snn_update_unit.sv | 61 ++++++
 rtl/spiking_neuron_array.sv | 89 ++++++++
 tb/tb_spiking_neuron_array.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared helpers for the time-multiplexed spiking neuron array: width/saturation
// functions and the per-visit outcome type used on the update datapath.
package snn_pkg;

   localparam int SNN_MAX_W = 16;
   localparam int SNN_ACC_W = 2*SNN_MAX_W + 2;

   typedef enum logic [1:0] {
      VISIT_INTEGRATE = 2'd0,
      VISIT_REFRAC    = 2'd1,
      VISIT_FIRE      = 2'd2
   } visit_kind_e;

   // Never returns less than 1 so a single-channel build still has a 1-bit pointer.
   function automatic int snn_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic logic signed [SNN_MAX_W-1:0] snn_sat(
      input logic signed [SNN_ACC_W-1:0] x,
      input int                          w
   );
      logic signed [SNN_ACC_W-1:0] hi;
      logic signed [SNN_ACC_W-1:0] lo;
      hi = (SNN_ACC_W'(1) <<< (w-1)) - SNN_ACC_W'(1);
      lo = -(SNN_ACC_W'(1) <<< (w-1));
      if (x > hi)      return hi[SNN_MAX_W-1:0];
      else if (x < lo) return lo[SNN_MAX_W-1:0];
      else             return x[SNN_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/spiking_neuron_array_if.sv
// Control/observe bundle of the spiking neuron array: stimulus, direct membrane
// load, monitor select and the spike/monitor outputs.
interface spiking_neuron_array_if
   import snn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4
);
   localparam int PW = snn_clog2(N_CH);

   logic                    en;
   logic [N_CH*WIDTH-1:0]   stim;
   logic                    ld;
   logic [PW-1:0]           ld_ch;
   logic signed [WIDTH-1:0] ld_val;
   logic [PW-1:0]           mon_sel;
   logic [N_CH-1:0]         spike;
   logic                    spike_any;
   logic signed [WIDTH-1:0] v_mon;
   logic [PW-1:0]           ptr;

   modport master (
      output en, stim, ld, ld_ch, ld_val, mon_sel,
      input  spike, spike_any, v_mon, ptr
   );

   modport slave (
      input  en, stim, ld, ld_ch, ld_val, mon_sel,
      output spike, spike_any, v_mon, ptr
   );
endinterface

// File: rtl/snn_update_unit.sv
// Combinational quadratic integrate-and-fire step for one channel visit.
// Define LEAK_EN to add a v>>>4 leak term to the integrate path.
module snn_update_unit
   import snn_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int THRESH   = 50,
   parameter int V_RESET  = -20,
   parameter int SHIFT_IN = 2,
   parameter int SHIFT_SQ = 3,
   parameter int REFRAC   = 2
) (
   input  logic signed [WIDTH-1:0] v_i,
   input  logic        [3:0]       rc_i,
   input  logic        [WIDTH-1:0] stim_i,
   output logic signed [WIDTH-1:0] v_o,
   output logic        [3:0]       rc_o,
   output visit_kind_e             kind_o
);
   localparam int AW = 2*WIDTH + 2;
   localparam logic signed [WIDTH-1:0] THRESH_W  = WIDTH'(THRESH);
   localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);

   logic signed [AW-1:0]        v_ext;
   logic signed [AW-1:0]        stim_ext;
   logic signed [AW-1:0]        q_ext;
   logic signed [AW-1:0]        sq;
   logic signed [AW-1:0]        leak;
   logic signed [AW-1:0]        sum;
   logic signed [SNN_MAX_W-1:0] sat_v;

   always_comb begin
      v_ext    = AW'(v_i);
      stim_ext = signed'({{(AW-WIDTH){1'b0}}, stim_i >> SHIFT_IN});
      q_ext    = v_ext >>> SHIFT_SQ;
      sq       = q_ext * q_ext;
`ifdef LEAK_EN
      leak     = v_ext >>> 4;
`else
      leak     = '0;
`endif
      sum      = v_ext + stim_ext + sq - leak;
      sat_v    = snn_sat(SNN_ACC_W'(sum), WIDTH);
   end

   always_comb begin
      v_o    = v_i;
      rc_o   = rc_i;
      kind_o = VISIT_INTEGRATE;
      if (v_i >= THRESH_W) begin
         v_o    = V_RESET_W;
         rc_o   = 4'(REFRAC);
         kind_o = VISIT_FIRE;
      end else if (rc_i != 4'd0) begin
         rc_o   = rc_i - 4'd1;
         kind_o = VISIT_REFRAC;
      end else begin
         v_o    = sat_v[WIDTH-1:0];
      end
   end
endmodule

// File: rtl/spiking_neuron_array.sv
// Round-robin array of N_CH integrate-and-fire neurons sharing one update unit.
// LEAK_EN (in snn_update_unit) optionally adds a membrane leak term.
module spiking_neuron_array
   import snn_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int N_CH     = 4,
   parameter int THRESH   = 50,
   parameter int V_RESET  = -20,
   parameter int SHIFT_IN = 2,
   parameter int SHIFT_SQ = 3,
   parameter int REFRAC   = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   spiking_neuron_array_if.slave bus
);
   localparam int            PW      = snn_clog2(N_CH);
   localparam logic [PW-1:0] LAST_CH = PW'(N_CH-1);

   logic signed [WIDTH-1:0] v_q  [N_CH];
   logic signed [WIDTH-1:0] v_d  [N_CH];
   logic [3:0]              rc_q [N_CH];
   logic [3:0]              rc_d [N_CH];
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [N_CH-1:0]         spike_q, spike_d;
   logic                    spike_any_q, spike_any_d;

   logic signed [WIDTH-1:0] v_nx;
   logic [3:0]              rc_nx;
   visit_kind_e             kind;
   logic                    collide;

   snn_update_unit #(
      .WIDTH(WIDTH), .THRESH(THRESH), .V_RESET(V_RESET),
      .SHIFT_IN(SHIFT_IN), .SHIFT_SQ(SHIFT_SQ), .REFRAC(REFRAC)
   ) u_update (
      .v_i    (v_q[ptr_q]),
      .rc_i   (rc_q[ptr_q]),
      .stim_i (bus.stim[ptr_q*WIDTH +: WIDTH]),
      .v_o    (v_nx),
      .rc_o   (rc_nx),
      .kind_o (kind)
   );

   // A direct load overrides the scheduled visit to the same channel and
   // suppresses its spike; the pointer still advances.
   always_comb begin
      v_d     = v_q;
      rc_d    = rc_q;
      ptr_d   = ptr_q;
      spike_d = '0;
      collide = bus.ld && (bus.ld_ch == ptr_q);
      if (bus.en) begin
         ptr_d        = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
         v_d[ptr_q]   = v_nx;
         rc_d[ptr_q]  = rc_nx;
         if ((kind == VISIT_FIRE) && !collide) spike_d[ptr_q] = 1'b1;
      end
      if (bus.ld) begin
         v_d[bus.ld_ch]  = bus.ld_val;
         rc_d[bus.ld_ch] = 4'd0;
      end
      spike_any_d = |spike_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            v_q[i]  <= '0;
            rc_q[i] <= '0;
         end
         ptr_q       <= '0;
         spike_q     <= '0;
         spike_any_q <= 1'b0;
      end else begin
         v_q         <= v_d;
         rc_q        <= rc_d;
         ptr_q       <= ptr_d;
         spike_q     <= spike_d;
         spike_any_q <= spike_any_d;
      end
   end

   assign bus.spike     = spike_q;
   assign bus.spike_any = spike_any_q;
   assign bus.ptr       = ptr_q;
   assign bus.v_mon     = v_q[bus.mon_sel];
endmodule

// File: tb/tb_spiking_neuron_array.sv
// Directed bench for spiking_neuron_array with an integer-arithmetic neuron model.
module tb_spiking_neuron_array;
   localparam int W        = 8;
   localparam int NC       = 4;
   localparam int THRESH   = 50;
   localparam int V_RESET  = -20;
   localparam int SHIFT_IN = 2;
   localparam int SHIFT_SQ = 3;
   localparam int REFRAC   = 2;
   localparam int VMAX     = (1 << (W-1)) - 1;
   localparam int VMIN     = -(1 << (W-1));

   logic clk;
   logic rst_n;

   spiking_neuron_array_if #(.WIDTH(W), .N_CH(NC)) bus ();

   spiking_neuron_array #(
      .WIDTH(W), .N_CH(NC), .THRESH(THRESH), .V_RESET(V_RESET),
      .SHIFT_IN(SHIFT_IN), .SHIFT_SQ(SHIFT_SQ), .REFRAC(REFRAC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit running = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference neurons in plain integers
   int mv  [NC];
   int mrc [NC];
   int mptr;
   int mspike;
   int p, q, nv;
   bit fire;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NC; i++) begin
            mv[i]  = 0;
            mrc[i] = 0;
         end
         mptr   = 0;
         mspike = 0;
      end else begin
         p      = mptr;
         fire   = 1'b0;
         mspike = 0;
         if (bus.en) begin
            if (mv[p] >= THRESH) begin
               mv[p]  = V_RESET;
               mrc[p] = REFRAC;
               fire   = 1'b1;
            end else if (mrc[p] > 0) begin
               mrc[p] = mrc[p] - 1;
            end else begin
               q  = mv[p] >>> SHIFT_SQ;
               nv = mv[p] + (int'(bus.stim[p*W +: W]) >> SHIFT_IN) + q*q;
`ifdef LEAK_EN
               nv = nv - (mv[p] >>> 4);
`endif
               if (nv > VMAX) nv = VMAX;
               if (nv < VMIN) nv = VMIN;
               mv[p] = nv;
            end
            mptr = (p + 1) % NC;
         end
         if (bus.ld) begin
            mv[bus.ld_ch]  = int'(bus.ld_val);
            mrc[bus.ld_ch] = 0;
            if (bus.en && (int'(bus.ld_ch) == p)) fire = 1'b0;
         end
         if (fire) mspike = 1 << p;
      end
   end

   always @(negedge clk) begin
      if (running) begin
         chk("cyc_spike",     int'(bus.spike),     mspike);
         chk("cyc_spike_any", int'(bus.spike_any), (mspike != 0) ? 1 : 0);
         chk("cyc_ptr",       int'(bus.ptr),       mptr);
         chk("cyc_v_mon",     int'(bus.v_mon),     mv[bus.mon_sel]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int exp_v0 [8] = '{10, 21, 35, 61, -20, -20, -20, -1};

   initial begin
      rst_n       = 1'b0;
      bus.en      = 1'b0;
      bus.stim    = '0;
      bus.ld      = 1'b0;
      bus.ld_ch   = '0;
      bus.ld_val  = '0;
      bus.mon_sel = '0;
      running     = 1'b1;
      step(3);
      rst_n  = 1'b1;
      bus.en = 1'b1;
      step(2);

      // load state, then reset mid-sweep
      bus.mon_sel = 2'd3;
      bus.ld      = 1'b1;
      bus.ld_ch   = 2'd3;
      bus.ld_val  = 8'sd33;
      step(1);
      bus.ld = 1'b0;
      chk("ld_before_rst", int'(bus.v_mon), 33);
      step(2);
      rst_n = 1'b0;
      #2;
      chk("async_rst_ptr", int'(bus.ptr), 0);
      chk("async_rst_v",   int'(bus.v_mon), 0);
      step(2);
      rst_n       = 1'b1;
      bus.mon_sel = 2'd0;
      for (int k = 0; k < 5; k++) begin
         chk("idle_ptr_seq", int'(bus.ptr), k % 4);
         chk("idle_spike",   int'(bus.spike), 0);
         step(1);
      end

      // integrate to fire, then refractory on channel 0
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      bus.stim[0*W +: W] = 8'd40;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("v0_visit", int'(bus.v_mon), exp_v0[i]);
         if (i == 4) begin
            chk("v0_spike",     int'(bus.spike), 1);
            chk("v0_spike_any", int'(bus.spike_any), 1);
         end else begin
            chk("v0_no_spike",  int'(bus.spike), 0);
         end
         if (i < 7) step(3);
      end
      bus.stim[0*W +: W] = 8'd0;

      // saturation on channel 1 (pointer is at 1)
      bus.en     = 1'b0;
      bus.ld     = 1'b1;
      bus.ld_ch  = 2'd1;
      bus.ld_val = 8'sd49;
      step(1);
      bus.ld      = 1'b0;
      bus.en      = 1'b1;
      bus.mon_sel = 2'd1;
      bus.stim[1*W +: W] = 8'd255;
      step(1);
      chk("sat_clamp", int'(bus.v_mon), 127);
      step(3);
      step(1);
      chk("sat_fire_spike", int'(bus.spike), 2);
      chk("sat_fire_v",     int'(bus.v_mon), -20);

      // load collides with the visit to channel 2
      bus.mon_sel = 2'd2;
      bus.ld      = 1'b1;
      bus.ld_ch   = 2'd2;
      bus.ld_val  = 8'sd100;
      step(1);
      bus.ld = 1'b0;
      chk("coll_no_spike", int'(bus.spike), 0);
      chk("coll_ptr",      int'(bus.ptr), 3);
      chk("coll_v",        int'(bus.v_mon), 100);
      step(3);
      step(1);
      chk("coll_next_spike", int'(bus.spike), 4);
      chk("coll_next_v",     int'(bus.v_mon), -20);

      // load to a channel other than the one visited
      bus.mon_sel = 2'd0;
      bus.ld      = 1'b1;
      bus.ld_ch   = 2'd0;
      bus.ld_val  = 8'sd7;
      step(1);
      bus.ld = 1'b0;
      chk("ld_other_v",   int'(bus.v_mon), 7);
      chk("ld_other_ptr", int'(bus.ptr), 0);

      // enable gating
      bus.en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("gate_ptr",   int'(bus.ptr), 0);
         chk("gate_v",     int'(bus.v_mon), 7);
         chk("gate_spike", int'(bus.spike), 0);
      end

      // leak (or plain integrate) from 32 with no stimulus
      bus.stim   = '0;
      bus.ld     = 1'b1;
      bus.ld_ch  = 2'd0;
      bus.ld_val = 8'sd32;
      step(1);
      bus.ld = 1'b0;
      bus.en = 1'b1;
      step(1);
`ifdef LEAK_EN
      chk("leak_v0", int'(bus.v_mon), 46);
`else
      chk("noleak_v0", int'(bus.v_mon), 48);
`endif
      step(4);
      running = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
